// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the push-button front-end.
//   - Channel indices (BTN_L/BTN_R/BTN_C) used by the button bus and by control_unit wiring.
//   - Default parameter values for button_conditioner and btn_debounce_ch.
//   - Debounce decision type used inside each channel.
package button_conditioner_pkg;

  // Bit positions on the button bus; control_unit uses the same indices.
  localparam int BTN_L = 0;
  localparam int BTN_R = 1;
  localparam int BTN_C = 2;

  localparam int NUM_BTN_DEF      = BTN_C + 1;
  localparam int TICK_DIV_DEF     = 100_000;  // 1 kHz sample tick at 100 MHz
  localparam int DB_SAMPLES_DEF   = 8;
  localparam int HOLD_TICKS_DEF   = 500;
  localparam int REPEAT_TICKS_DEF = 100;

  // Outcome of inspecting the sample window on a given clk.
  typedef enum logic [1:0] {
    DB_HOLD    = 2'd0,  // mixed samples: keep the current level
    DB_PRESS   = 2'd1,  // window all ones
    DB_RELEASE = 2'd2   // window all zeros
  } db_decision_e;

endpackage : button_conditioner_pkg

// File: rtl/btn_debounce_ch.sv
// One push-button channel: 2-FF synchroniser, tick-sampled debounce window, debounced level,
// rising-edge pulse and (optionally) hold/auto-repeat pulses.
// Ports:
//   clk      in  system clock
//   reset    in  asynchronous, active-high reset
//   i_tick   in  shared sample-tick strobe (1 clk wide)
//   i_raw    in  raw pad level, asynchronous to clk
//   o_level  out debounced level
//   o_pulse  out 1-clk pulse on press edge or auto-repeat
module btn_debounce_ch
  import button_conditioner_pkg::*;
#(
  parameter int DB_SAMPLES   = DB_SAMPLES_DEF,
  parameter int HOLD_TICKS   = HOLD_TICKS_DEF,
  parameter int REPEAT_TICKS = REPEAT_TICKS_DEF,
  parameter bit REPEAT_EN    = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_tick,
  input  logic i_raw,
  output logic o_level,
  output logic o_pulse
);

  localparam logic [DB_SAMPLES-1:0] ALL_ONES  = {DB_SAMPLES{1'b1}};
  localparam logic [DB_SAMPLES-1:0] ALL_ZEROS = {DB_SAMPLES{1'b0}};

  logic                  sync_meta;
  logic                  sync_q;
  logic [DB_SAMPLES-1:0] samples;
  logic                  level_d1;
  logic                  rise;
  logic                  repeat_hit;
  db_decision_e          decision;

  // NOTE: every flop uses non-blocking assignment so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      sync_meta <= i_raw;
      sync_q    <= sync_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      samples <= ALL_ZEROS;
    end else if (i_tick) begin
      samples <= {samples[DB_SAMPLES-2:0], sync_q};
    end
  end

  // NOTE: default assigned first so no path through always_comb leaves decision unassigned (no latch).
  always_comb begin
    decision = DB_HOLD;
    if (samples == ALL_ONES) begin
      decision = DB_PRESS;
    end else if (samples == ALL_ZEROS) begin
      decision = DB_RELEASE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_level  <= 1'b0;
      level_d1 <= 1'b0;
    end else begin
      level_d1 <= o_level;
      unique case (decision)
        DB_PRESS:   o_level <= 1'b1;
        DB_RELEASE: o_level <= 1'b0;
        default:    o_level <= o_level;
      endcase
    end
  end

  assign rise = o_level & ~level_d1;

  generate
    if (REPEAT_EN) begin : g_repeat
      localparam int HW = $clog2(HOLD_TICKS + 1);
      localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS);
      localparam logic [HW-1:0] RELOAD   = HW'(HOLD_TICKS - REPEAT_TICKS);

      logic [HW-1:0] hold_cnt;
      logic [HW-1:0] hold_inc;

      assign hold_inc   = hold_cnt + HW'(1);
      // Rise and tick never share a clk (level moves one clk after a tick), but the clear wins anyway.
      assign repeat_hit = o_level & ~rise & i_tick & (hold_inc == HOLD_MAX);

      // Reaching HOLD_TICKS reloads instead of wrapping, so repeats follow every REPEAT_TICKS.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          hold_cnt <= '0;
        end else if (!o_level || rise) begin
          hold_cnt <= '0;
        end else if (i_tick) begin
          hold_cnt <= (hold_inc == HOLD_MAX) ? RELOAD : hold_inc;
        end
      end
    end else begin : g_no_repeat
      assign repeat_hit = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_pulse <= 1'b0;
    end else begin
      o_pulse <= rise | repeat_hit;
    end
  end

endmodule : btn_debounce_ch

// File: rtl/button_conditioner.sv
// Push-button front-end between the board pads (L, R, C) and control_unit.
// One free-running sample-tick generator shared by NUM_BTN debounce channels.
// Ports:
//   clk          in  system clock
//   reset        in  asynchronous, active-high reset
//   i_btn_raw    in  [NUM_BTN] raw pad levels, active-high, asynchronous
//   o_btn_level  out [NUM_BTN] debounced levels
//   o_btn_pulse  out [NUM_BTN] 1-clk pulses (press edge or auto-repeat)
//   o_tick       out sample-tick strobe, 1 clk wide every TICK_DIV clks
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int                   NUM_BTN      = NUM_BTN_DEF,
  parameter int                   TICK_DIV     = TICK_DIV_DEF,
  parameter int                   DB_SAMPLES   = DB_SAMPLES_DEF,
  parameter int                   HOLD_TICKS   = HOLD_TICKS_DEF,
  parameter int                   REPEAT_TICKS = REPEAT_TICKS_DEF,
  parameter logic [NUM_BTN-1:0]   REPEAT_MASK  = NUM_BTN'((1 << BTN_L) | (1 << BTN_R))
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] i_btn_raw,
  output logic [NUM_BTN-1:0] o_btn_level,
  output logic [NUM_BTN-1:0] o_btn_pulse,
  output logic               o_tick
);

  localparam int              TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0] tick_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  // Decoded from the counter so the strobe is 0 straight out of reset and exactly TICK_DIV apart.
  assign o_tick = (tick_cnt == TICK_LAST);

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    btn_debounce_ch #(
      .DB_SAMPLES  (DB_SAMPLES),
      .HOLD_TICKS  (HOLD_TICKS),
      .REPEAT_TICKS(REPEAT_TICKS),
      .REPEAT_EN   (REPEAT_MASK[g])
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .i_tick (o_tick),
      .i_raw  (i_btn_raw[g]),
      .o_level(o_btn_level[g]),
      .o_pulse(o_btn_pulse[g])
    );
  end

endmodule : button_conditioner

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner with small timing parameters.
module tb_button_conditioner;
  import button_conditioner_pkg::*;

  localparam int              NB   = 3;
  localparam int              TD   = 10;
  localparam int              DB   = 4;
  localparam int              HOLD = 20;
  localparam int              REP  = 5;
  localparam logic [NB-1:0]   MASK = 3'b011;

  logic          clk;
  logic          reset;
  logic [NB-1:0] raw;
  logic [NB-1:0] lvl;
  logic [NB-1:0] pulse;
  logic          tick;

  int n_cmp = 0;
  int n_err = 0;

  button_conditioner #(
    .NUM_BTN     (NB),
    .TICK_DIV    (TD),
    .DB_SAMPLES  (DB),
    .HOLD_TICKS  (HOLD),
    .REPEAT_TICKS(REP),
    .REPEAT_MASK (MASK)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_btn_raw  (raw),
    .o_btn_level(lvl),
    .o_btn_pulse(pulse),
    .o_tick     (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: counts edges since reset for the tick, delays raw by two clks, keeps
  // run lengths of equal tick samples, and counts ticks held since the press to place repeats.
  logic [NB-1:0] m_d1, m_d2, m_lvl, m_lvl_prev, m_pulse;
  logic          m_tick;
  int            m_edges;
  int            m_run1[NB];
  int            m_run0[NB];
  int            m_held[NB];

  always @(posedge clk or posedge reset) begin
    logic tick_now;
    logic lvl_new;
    logic rpt;
    if (reset) begin
      m_d1 = '0; m_d2 = '0; m_lvl = '0; m_lvl_prev = '0; m_pulse = '0;
      m_tick = 1'b0; m_edges = 0;
      for (int i = 0; i < NB; i++) begin
        m_run1[i] = 0; m_run0[i] = 0; m_held[i] = 0;
      end
    end else begin
      tick_now = ((m_edges % TD) == TD - 1);
      for (int i = 0; i < NB; i++) begin
        if (m_run1[i] >= DB)      lvl_new = 1'b1;
        else if (m_run0[i] >= DB) lvl_new = 1'b0;
        else                      lvl_new = m_lvl[i];
        rpt = 1'b0;
        if (!m_lvl[i]) begin
          m_held[i] = 0;
        end else if (tick_now) begin
          m_held[i]++;
          rpt = MASK[i] && (m_held[i] >= HOLD) && (((m_held[i] - HOLD) % REP) == 0);
        end
        m_pulse[i] = (m_lvl[i] && !m_lvl_prev[i]) || rpt;
        if (tick_now) begin
          if (m_d2[i]) begin
            m_run1[i] = (m_run1[i] < DB) ? m_run1[i] + 1 : DB;
            m_run0[i] = 0;
          end else begin
            m_run0[i] = (m_run0[i] < DB) ? m_run0[i] + 1 : DB;
            m_run1[i] = 0;
          end
        end
        m_lvl_prev[i] = m_lvl[i];
        m_lvl[i]      = lvl_new;
      end
      m_d2 = m_d1;
      m_d1 = raw;
      m_edges++;
      m_tick = ((m_edges % TD) == TD - 1);
    end
  end

  // Monitor: compares every output against the model away from the active edge.
  bit            mon_en = 1'b0;
  int            cyc = 0;
  int            last_tick = -1;
  logic [NB-1:0] prev_pulse = '0;
  logic [NB-1:0] lvl_seen = '0;
  int            pcount[NB];
  int            pq0[$];
  int            pq1[$];

  always @(negedge clk) begin
    if (mon_en) begin
      check("no_x", 32'($isunknown({tick, lvl, pulse})), 32'd0);
      check("tick", 32'(tick), 32'(m_tick));
      check("level", 32'(lvl), 32'(m_lvl));
      check("pulse", 32'(pulse), 32'(m_pulse));
      check("pulse_width", 32'(pulse & prev_pulse), 32'd0);
      if (reset) begin
        last_tick = -1;
      end else if (tick) begin
        if (last_tick >= 0) check("tick_period", cyc - last_tick, TD);
        last_tick = cyc;
      end
      lvl_seen |= lvl;
      for (int i = 0; i < NB; i++) if (pulse[i]) pcount[i]++;
      if (pulse[0]) pq0.push_back(cyc);
      if (pulse[1]) pq1.push_back(cyc);
    end
    prev_pulse = pulse;
    cyc++;
  end

  task automatic cyc_wait(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_pulse(input int ch, input int budget, input string tag);
    bit seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      if (pulse[ch]) seen = 1'b1;
    end
    #1;
    check(tag, 32'(seen), 32'd1);
  endtask

  task automatic wait_level(input int ch, input logic val, input int budget, input string tag);
    bit seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      if (lvl[ch] === val) seen = 1'b1;
    end
    #1;
    check(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base[NB];
    int nt;
    int dur;
    for (int i = 0; i < NB; i++) pcount[i] = 0;
    reset = 1'b1;
    raw   = '0;
    repeat (2) @(negedge clk);
    #1 mon_en = 1'b1;
    @(negedge clk);
    check("reset_outputs", 32'({tick, lvl, pulse}), 32'd0);
    #1 reset = 1'b0;

    // 1: clean press on L
    for (int i = 0; i < NB; i++) base[i] = pcount[i];
    raw = 3'b001;
    cyc_wait(100);
    check("s1_level", 32'(lvl), 32'b001);
    raw = 3'b000;
    cyc_wait(100);
    check("s1_level_released", 32'(lvl), 32'b000);
    check("s1_pulses_l", pcount[BTN_L] - base[BTN_L], 1);
    check("s1_pulses_r", pcount[BTN_R] - base[BTN_R], 0);
    check("s1_pulses_c", pcount[BTN_C] - base[BTN_C], 0);

    // 2: bouncing R never debounces
    for (int i = 0; i < NB; i++) base[i] = pcount[i];
    lvl_seen = '0;
    for (int k = 0; k < 14; k++) begin
      raw[BTN_R] = ~raw[BTN_R];
      cyc_wait(15);
    end
    raw = 3'b000;
    cyc_wait(60);
    check("s2_level_never", 32'(lvl_seen[BTN_R]), 32'd0);
    check("s2_pulses_r", pcount[BTN_R] - base[BTN_R], 0);

    // 3: auto-repeat on L
    pq0.delete();
    raw = 3'b001;
    cyc_wait(400);
    check("s3_min_pulses", 32'(pq0.size() >= 3), 32'd1);
    if (pq0.size() >= 3) begin
      check("s3_first_repeat_gap", pq0[1] - pq0[0], HOLD * TD - 2);
      for (int k = 2; k < pq0.size(); k++) check("s3_repeat_gap", pq0[k] - pq0[k-1], REP * TD);
    end
    raw = 3'b000;
    cyc_wait(30);
    check("s3_level_still_high", 32'(lvl[BTN_L]), 32'd1);
    wait_level(BTN_L, 1'b0, 60, "s3_level_falls");
    base[BTN_L] = pcount[BTN_L];
    cyc_wait(100);
    check("s3_no_pulse_after_release", pcount[BTN_L] - base[BTN_L], 0);

    // 4: C never repeats
    base[BTN_C] = pcount[BTN_C];
    raw = 3'b100;
    cyc_wait(400);
    raw = 3'b000;
    cyc_wait(80);
    check("s4_pulses_c", pcount[BTN_C] - base[BTN_C], 1);

    // 5: simultaneous press of L and R
    pq0.delete();
    pq1.delete();
    raw = 3'b011;
    cyc_wait(100);
    check("s5_pulses_l", pq0.size(), 1);
    check("s5_pulses_r", pq1.size(), 1);
    if (pq0.size() == 1 && pq1.size() == 1) check("s5_same_clk", pq1[0], pq0[0]);
    raw = 3'b000;
    cyc_wait(80);

    // 6: reset at hold tick 10 with L still held
    raw = 3'b001;
    wait_pulse(BTN_L, 80, "s6_first_edge");
    nt = 0;
    for (int n = 0; n < 200 && nt < 10; n++) begin
      @(negedge clk);
      if (tick) nt++;
    end
    check("s6_hold_ticks", nt, 10);
    #1 reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("s6_reset_outputs", 32'({tick, lvl, pulse}), 32'd0);
    end
    #1 reset = 1'b0;
    pq0.delete();
    cyc_wait(300);
    check("s6_min_pulses", 32'(pq0.size() >= 2), 32'd1);
    if (pq0.size() >= 2) check("s6_repeat_restart_gap", pq0[1] - pq0[0], HOLD * TD - 2);
    raw = 3'b000;
    cyc_wait(80);

    // Random patterns, holds and resets, checked cycle by cycle against the model
    for (int it = 0; it < 150; it++) begin
      raw = NB'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b1;
        cyc_wait($urandom_range(1, 3));
        reset = 1'b0;
      end
      dur = ($urandom_range(0, 9) == 0) ? 260 : $urandom_range(1, 60);
      cyc_wait(dur);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_button_conditioner
